spi_ddr_rx_deser: RTL and testbench

Read-path counterpart of the SPI master's DDR output stage. Takes the bit pairs captured on both edges of the flash clock (rising-edge bit and falling-edge bit, presented together once per system clock) during a DTR read, skips capture latency and dummy cycles, and packs the stream MSB-first into bytes. Bytes go to the SPI master's read-data path through a 2-entry valid/ready buffer with sticky overflow detection.

---
 rtl/spi_ddr_rx_deser_if.sv | 19 +
 rtl/spi_ddr_rx_deser.sv | 150 +++++++++++++++
 tb/tb_spi_ddr_rx_deser.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_ddr_rx_deser_if.sv
// Read-data stream from the DDR deserializer
// into the SPI master's read path.
interface spi_ddr_rx_deser_if;
  logic [7:0] data_out;
  logic       data_vld;
  logic       data_rdy;

  modport master (
    output data_out,
    output data_vld,
    input  data_rdy
  );

  modport slave (
    input  data_out,
    input  data_vld,
    output data_rdy
  );
endinterface

// File: rtl/spi_ddr_rx_deser.sv
// DTR read deserializer: skips latency/dummy,
// packs DDR bit pairs MSB-first into bytes.
module spi_ddr_rx_deser #(
  parameter int CAP_LAT = 1,
  parameter int DUMMY_W = 5,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DUMMY_W-1:0] dummy,
  input  logic [LEN_W-1:0]   len,
  input  logic               abort,
  input  logic               d_p,
  input  logic               d_n,
  spi_ddr_rx_deser_if.master rd,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int SW = DUMMY_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    DATA,
    DONE
  } state_t;

  state_t           state;
  logic [SW-1:0]    skip_cnt;
  logic [SW-1:0]    skip_ld;
  logic [LEN_W-1:0] byte_cnt;
  logic [5:0]       sh;
  logic [1:0]       pcnt;
  logic [7:0]       byte_new;
  logic [7:0]       mem0;
  logic [7:0]       mem1;
  logic [1:0]       fcnt;
  logic             go;
  logic             push;
  logic             pop;
  logic             full;

  assign skip_ld  = SW'(CAP_LAT) + SW'(dummy);
  assign byte_new = {sh, d_p, d_n};
  assign go       = start && (state == IDLE);
  assign push     = (state == DATA) && (pcnt == 2'd3) && !abort;
  assign pop      = rd.data_vld && rd.data_rdy;
  assign full     = (fcnt == 2'd2);

  assign rd.data_out = mem0;
  assign rd.data_vld = (fcnt != 2'd0);

  // Transfer sequencing, pair packing and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      skip_cnt <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      pcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
        sh    <= '0;
        pcnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              skip_cnt <= skip_ld;
              byte_cnt <= len;
              sh       <= '0;
              pcnt     <= '0;
              if (len == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else if (skip_ld == '0) begin
                state <= DATA;
                busy  <= 1'b1;
              end else begin
                state <= SKIP;
                busy  <= 1'b1;
              end
            end
          end
          SKIP: begin
            skip_cnt <= skip_cnt - SW'(1);
            if (skip_cnt == SW'(1)) state <= DATA;
          end
          DATA: begin
            sh   <= byte_new[5:0];
            pcnt <= pcnt + 2'd1;
            if (pcnt == 2'd3) begin
              byte_cnt <= byte_cnt - LEN_W'(1);
              if (byte_cnt == LEN_W'(1)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Two-entry output buffer with sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0     <= '0;
      mem1     <= '0;
      fcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      if (go) overflow <= 1'b0;
      else if (push && full && !pop) overflow <= 1'b1;
      unique case (1'b1)
        push && pop: begin
          if (fcnt == 2'd1) begin
            mem0 <= byte_new;
          end else begin
            mem0 <= mem1;
            mem1 <= byte_new;
          end
        end
        push && !pop && !full: begin
          if (fcnt == 2'd0) mem0 <= byte_new;
          else mem1 <= byte_new;
          fcnt <= fcnt + 2'd1;
        end
        !push && pop: begin
          mem0 <= mem1;
          fcnt <= fcnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ddr_rx_deser.sv
// Bench for spi_ddr_rx_deser: directed and
// randomized transfers against a queue model.
module tb_spi_ddr_rx_deser;
  localparam int CAP_LAT = 1;
  localparam int DUMMY_W = 5;
  localparam int LEN_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [DUMMY_W-1:0] dummy;
  logic [LEN_W-1:0]   len;
  logic               abort;
  logic               d_p;
  logic               d_n;
  logic               busy;
  logic               done;
  logic               overflow;

  spi_ddr_rx_deser_if rd_if ();

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  bit         m_ovf;
  logic [7:0] got[$];
  logic [1:0] fix[$];

  always #5 clk = ~clk;

  spi_ddr_rx_deser #(
    .CAP_LAT (CAP_LAT),
    .DUMMY_W (DUMMY_W),
    .LEN_W   (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dummy    (dummy),
    .len      (len),
    .abort    (abort),
    .d_p      (d_p),
    .d_n      (d_n),
    .rd       (rd_if),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One transfer started at cycle 0. The model:
  // byte k = pairs 4k..4k+3 concatenated, ready at
  // edge S+4k+4; buffer is a queue of depth 2.
  task automatic xfer(input int dm, input int n,
                      input int rmode, input int rrel,
                      input int ab_at, input int st2_at);
    int s, fin, last, done_c, ab, sz0, k;
    logic [1:0] pr[];
    logic [7:0] bv[];
    bit rdy, comp;
    s  = CAP_LAT + dm;
    ab = (ab_at < 0) ? 1000000 : ab_at;
    pr = new[4 * n];
    for (int i = 0; i < 4 * n; i++)
      pr[i] = (fix.size() > 0) ? fix.pop_front()
                               : 2'($urandom_range(0, 3));
    bv = new[n];
    for (int j = 0; j < n; j++)
      bv[j] = {pr[4*j], pr[4*j+1], pr[4*j+2], pr[4*j+3]};
    fin    = (n == 0) ? 1 : s + 4 * n + 1;
    done_c = (ab_at < 0) ? fin : -1;
    last   = fin + 6;
    if (rmode == 2 && rrel + 4 > last) last = rrel + 4;
    got.delete();
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      chk("busy", 32'(busy),
          32'(n > 0 && c >= 1 && c <= s + 4 * n && c <= ab));
      chk("done", 32'(done), 32'(c == done_c));
      chk("data_vld", 32'(rd_if.data_vld), 32'(mq.size() > 0));
      if (mq.size() > 0)
        chk("data_out", 32'(rd_if.data_out), 32'(mq[0]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      start = (c == 0) || (c == st2_at);
      dummy = (c == 0) ? DUMMY_W'(dm) : DUMMY_W'($urandom);
      len   = (c == 0) ? LEN_W'(n)
                       : LEN_W'($urandom_range(1, 9));
      abort = (c == ab_at);
      if (c >= s + 1 && c <= s + 4 * n)
        {d_p, d_n} = pr[c-s-1];
      else
        {d_p, d_n} = 2'($urandom);
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = (c > fin) ? 1'b1 : 1'($urandom_range(0, 1));
        2: rdy = (c >= rrel);
        3: rdy = 1'b0;
        default:
          rdy = (c > fin) ||
                (c >= s + 12 && c < fin && (c - s) % 4 == 0);
      endcase
      rd_if.data_rdy = rdy;
      if (rd_if.data_vld && rdy) got.push_back(rd_if.data_out);
      @(posedge clk);
      sz0 = mq.size();
      if (c == 0) m_ovf = 1'b0;
      if (sz0 > 0 && rdy) void'(mq.pop_front());
      comp = n > 0 && c >= s + 4 && c <= s + 4 * n &&
             (c - s) % 4 == 0 && c < ab;
      if (comp) begin
        k = (c - s) / 4 - 1;
        if (sz0 == 2 && !rdy) m_ovf = 1'b1;
        else mq.push_back(bv[k]);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dummy = '0;
    len   = '0;
    abort = 1'b0;
    d_p   = 1'b0;
    d_n   = 1'b0;
    rd_if.data_rdy = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vld", 32'(rd_if.data_vld), 32'd0);
    chk("rst_dout", 32'(rd_if.data_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    fix = '{2'b11, 2'b00, 2'b11, 2'b00,
            2'b10, 2'b10, 2'b10, 2'b10};
    xfer(6, 2, 0, 0, -1, -1);
    chk("dir_cnt", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("dir_b0", 32'(got[0]), 32'hCC);
      chk("dir_b1", 32'(got[1]), 32'hAA);
    end

    xfer(3, 0, 0, 0, -1, -1);
    chk("len0_nodata", 32'(got.size()), 32'd0);

    xfer(2, 4, 2, CAP_LAT + 2 + 16 + 3, -1, -1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(got.size()), 32'd2);

    xfer(1, 4, 4, 0, -1, -1);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_cnt", 32'(got.size()), 32'd4);

    xfer(2, 3, 0, 0, CAP_LAT + 2 + 6, -1);
    chk("abort_cnt", 32'(got.size()), 32'd1);

    for (int t = 0; t < 5; t++)
      xfer(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)),
           1, 0, -1, (t % 2 == 1) ? 3 : -1);

    xfer(0, 3, 3, 0, -1, -1);
    @(negedge clk);
    start = 1'b1;
    dummy = DUMMY_W'(2);
    len   = LEN_W'(5);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_vld", 32'(rd_if.data_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_vld", 32'(rd_if.data_vld), 32'd0);
    chk("mid_rst_dout", 32'(rd_if.data_out), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    xfer(4, 2, 0, 0, -1, 5);
    chk("post_rst_cnt", 32'(got.size()), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
